// File: rtl/dmem_arbiter.sv
// Two-port word-access arbiter for a single-port byte memory with a registered read.
// Define DMEM_ARB_FAIR_EN for round-robin arbitration; the default is fixed priority (port 0 first).
module dmem_arbiter #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_ack,
    output logic        p0_err,
    output logic [31:0] p0_rdata,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_ack,
    output logic        p1_err,
    output logic [31:0] p1_rdata,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,

    output logic        busy,
    output logic        gnt_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        lat_err;
    logic        gnt_q;

    logic        any_req;
    logic        pick;
    logic        win_we;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;
    logic        win_err;

`ifdef DMEM_ARB_FAIR_EN
    logic        ptr;
`endif

    assign any_req = p0_req | p1_req;

    // Winner selection: a lone requester always wins; contention resolved by priority or pointer.
    always_comb begin
        pick = 1'b0;
`ifdef DMEM_ARB_FAIR_EN
        if (p0_req && p1_req) begin
            pick = ptr;
        end else begin
            pick = p1_req;
        end
`else
        pick = p1_req & ~p0_req;
`endif
    end

    always_comb begin
        win_we    = pick ? p1_we    : p0_we;
        win_addr  = pick ? p1_addr  : p0_addr;
        win_wdata = pick ? p1_wdata : p0_wdata;
        win_err   = (win_addr[1:0] != 2'b00) || ((win_addr >> ADDR_W) != 32'd0);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nx = win_err ? RESP : ISSUE;
                end
            end
            ISSUE:   state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The request is captured at grant so later payload changes cannot disturb the access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lat_we    <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_err   <= 1'b0;
            gnt_q     <= 1'b0;
`ifdef DMEM_ARB_FAIR_EN
            ptr       <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (state == IDLE && any_req) begin
                lat_we    <= win_we;
                lat_addr  <= win_addr;
                lat_wdata <= win_wdata;
                lat_err   <= win_err;
                gnt_q     <= pick;
`ifdef DMEM_ARB_FAIR_EN
                ptr       <= ~pick;
`endif
            end
        end
    end

    always_comb begin
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_we    = 1'b0;
        p0_ack    = 1'b0;
        p0_err    = 1'b0;
        p0_rdata  = 32'd0;
        p1_ack    = 1'b0;
        p1_err    = 1'b0;
        p1_rdata  = 32'd0;
        case (state)
            ISSUE: begin
                mem_addr  = lat_addr;
                mem_wdata = lat_wdata;
                mem_we    = lat_we;
            end
            RESP: begin
                // Read data arrives from the memory register exactly in this cycle.
                if (gnt_q) begin
                    p1_ack   = 1'b1;
                    p1_err   = lat_err;
                    p1_rdata = (!lat_we && !lat_err) ? mem_rdata : 32'd0;
                end else begin
                    p0_ack   = 1'b1;
                    p0_err   = lat_err;
                    p0_rdata = (!lat_we && !lat_err) ? mem_rdata : 32'd0;
                end
            end
            default: ;
        endcase
    end

    assign busy   = (state != IDLE);
    assign gnt_id = gnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter: a word-level reference model predicts
// grant order, ack timing, error flags and read data; a monitor checks every ack.
module tb_dmem_arbiter;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_ack, p0_err, p1_ack, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, busy, gnt_id;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int we_cycles = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .busy(busy), .gnt_id(gnt_id)
    );

    // Byte-wide memory with a registered read port.
    logic [7:0]        mem_bytes [0:DEPTH-1];
    logic [ADDR_W-1:0] ma;
    assign ma = mem_addr[ADDR_W-1:0];

    initial for (int i = 0; i < DEPTH; i++) mem_bytes[i] <= 8'h00;

    always @(posedge clk) begin
        if (mem_we) begin
            mem_bytes[ma]              <= mem_wdata[7:0];
            mem_bytes[ma + ADDR_W'(1)] <= mem_wdata[15:8];
            mem_bytes[ma + ADDR_W'(2)] <= mem_wdata[23:16];
            mem_bytes[ma + ADDR_W'(3)] <= mem_wdata[31:24];
        end
        mem_rdata <= {mem_bytes[ma + ADDR_W'(3)], mem_bytes[ma + ADDR_W'(2)],
                      mem_bytes[ma + ADDR_W'(1)], mem_bytes[ma]};
        cyc <= cyc + 1;
        if (mem_we) we_cycles <= we_cycles + 1;
    end

    // Reference model: word array, arbitration order and ack timing as plain arithmetic.
    typedef struct {
        bit          port;
        bit          err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic [31:0] ref_words [0:DEPTH/4-1];
    exp_t        expq [$];
    bit          ref_ptr = 1'b0;

    initial for (int i = 0; i < DEPTH/4; i++) ref_words[i] = 32'd0;

    function automatic bit addrBad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= DEPTH);
    endfunction

    task automatic modelAccess(input bit port, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input int start, output int ack);
        exp_t e;
        e.port  = port;
        e.err   = addrBad(addr);
        e.rdata = 32'd0;
        if (!e.err) begin
            if (we) ref_words[addr / 4] = wdata;
            else    e.rdata = ref_words[addr / 4];
        end
        ack   = start + (e.err ? 1 : 2);
        e.cyc = ack;
        expq.push_back(e);
        ref_ptr = ~port;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic setReq(input bit port, input bit req, input bit we,
                          input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end
    endtask

    task automatic waitAck(input bit port);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (port ? p1_ack : p0_ack) begin
                if (port) p1_req = 1'b0; else p0_req = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("[TB] FAIL ack_timeout_p%0d: got no ack expected ack within 12 cycles", port);
        if (port) p1_req = 1'b0; else p0_req = 1'b0;
    endtask

    // Called just after a falling edge with the arbiter idle.
    task automatic applyStimulus(input bit use0, input bit we0, input logic [31:0] a0, input logic [31:0] d0,
                                 input bit use1, input bit we1, input logic [31:0] a1, input logic [31:0] d1);
        int ack_a, ack_b;
        bit first;
`ifdef DMEM_ARB_FAIR_EN
        first = (use0 && use1) ? ref_ptr : use1;
`else
        first = !use0;
`endif
        if (first) modelAccess(1'b1, we1, a1, d1, cyc, ack_a);
        else       modelAccess(1'b0, we0, a0, d0, cyc, ack_a);
        if (use0 && use1) begin
            if (first) modelAccess(1'b0, we0, a0, d0, ack_a + 1, ack_b);
            else       modelAccess(1'b1, we1, a1, d1, ack_a + 1, ack_b);
        end
        if (use0) setReq(1'b0, 1'b1, we0, a0, d0);
        if (use1) setReq(1'b1, 1'b1, we1, a1, d1);
        fork
            begin if (use0) waitAck(1'b0); end
            begin if (use1) waitAck(1'b1); end
        join
        repeat (2) @(negedge clk);
    endtask

    // Monitor: every ack is popped against the scoreboard; quiet cycles must be clean.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (p0_ack || p1_ack) begin
                if (expq.size() == 0) begin
                    checkOutput("unexpected_ack", {30'd0, p1_ack, p0_ack}, 32'd0);
                end else begin
                    e = expq.pop_front();
                    checkOutput("ack_pair", {30'd0, p1_ack, p0_ack}, e.port ? 32'd2 : 32'd1);
                    checkOutput("gnt_id", {31'd0, gnt_id}, {31'd0, e.port});
                    checkOutput("ack_cycle", cyc, e.cyc);
                    checkOutput("err", {31'd0, e.port ? p1_err : p0_err}, {31'd0, e.err});
                    checkOutput("rdata", e.port ? p1_rdata : p0_rdata, e.rdata);
                    checkOutput("other_rdata", e.port ? p0_rdata : p1_rdata, 32'd0);
                    checkOutput("resp_mem_we", {31'd0, mem_we}, 32'd0);
                end
            end else if (!rst) begin
                checkOutput("quiet_outputs", {28'd0, p0_err, p1_err, |p0_rdata, |p1_rdata}, 32'd0);
            end
        end
    end

    function automatic logic [31:0] randAddr();
        case ($urandom_range(0, 9))
            0:       return 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(1, 3));
            1:       return 32'h0000_0400;
            2:       return 32'hFFFF_FFFC;
            3:       return 32'h0000_03FC;
            default: return 32'($urandom_range(0, 15)) * 4;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w0, start, nacks;
        rst = 1'b1;
        setReq(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        setReq(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_gnt_id", {31'd0, gnt_id}, 32'd0);
        checkOutput("reset_mem_we", {31'd0, mem_we}, 32'd0);
        checkOutput("reset_mem_addr", mem_addr, 32'd0);
        checkOutput("reset_mem_wdata", mem_wdata, 32'd0);
        checkOutput("reset_acks", {30'd0, p0_ack, p1_ack}, 32'd0);
        @(negedge clk);

        $display("[TB] write then read from both ports");
        applyStimulus(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
        applyStimulus(1, 0, 32'h10, 32'h0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 32'h10, 32'h0);

        $display("[TB] simultaneous requests");
        applyStimulus(1, 1, 32'h20, 32'hA5A5A5A5, 0, 0, 0, 0);
        applyStimulus(1, 0, 32'h20, 32'h0, 1, 1, 32'h20, 32'h12345678);
        applyStimulus(1, 0, 32'h20, 32'h0, 0, 0, 0, 0);

        $display("[TB] error accesses");
        applyStimulus(1, 1, 32'h0, 32'h5A5A0001, 0, 0, 0, 0);
        w0 = we_cycles;
        applyStimulus(0, 0, 0, 0, 1, 1, 32'h2, 32'hFFFFFFFF);
        checkOutput("err_write_no_mem_we", we_cycles - w0, 32'd0);
        applyStimulus(1, 0, 32'h400, 32'h0, 0, 0, 0, 0);
        applyStimulus(1, 0, 32'h0, 32'h0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 32'h3FE, 32'h0);
        applyStimulus(1, 1, 32'hFFFFFFFC, 32'h1, 0, 0, 0, 0);

        $display("[TB] top boundary");
        applyStimulus(1, 1, 32'h3FC, 32'hCAFEF00D, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 32'h3FC, 32'h0);

        $display("[TB] reset during grant");
        w0 = we_cycles;
        setReq(1'b0, 1'b1, 1'b1, 32'h30, 32'h11111111);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        p0_req = 1'b0;
        ref_ptr = 1'b0;
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        checkOutput("rst_busy_after", {31'd0, busy}, 32'd0);
        checkOutput("rst_no_write", we_cycles - w0, 32'd0);
        @(negedge clk);
        applyStimulus(1, 0, 32'h30, 32'h0, 0, 0, 0, 0);

        $display("[TB] held request with payload change after grant");
        applyStimulus(1, 1, 32'h40, 32'h40404040, 0, 0, 0, 0);
        applyStimulus(1, 1, 32'h44, 32'h44444444, 0, 0, 0, 0);
        start = cyc;
        modelAccess(1'b0, 1'b0, 32'h40, 32'h0, start, w0);
        modelAccess(1'b0, 1'b0, 32'h44, 32'h0, w0 + 1, w0);
        setReq(1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
        nacks = 0;
        for (int i = 0; i < 12 && nacks < 2; i++) begin
            @(negedge clk);
            if (i == 0) p0_addr = 32'h44;
            if (p0_ack) nacks++;
        end
        p0_req = 1'b0;
        checkOutput("held_ack_count", nacks, 32'd2);
        repeat (2) @(negedge clk);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 60; n++) begin
            int kind;
            kind = $urandom_range(0, 2);
            applyStimulus(kind != 1, 1'($urandom_range(0, 1)), randAddr(), $urandom(),
                          kind != 0, 1'($urandom_range(0, 1)), randAddr(), $urandom());
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", expq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port, byte-addressed, little-endian data memory between two word-access requesters: port 0 (core load/store path) and port 1 (debug/loader).
- Sequences each access around the memory's one-cycle registered read: issue a write or read, then return data/ack.
- Rejects misaligned or out-of-range words without touching memory.

Parameters:
- ADDR_W, 10, byte-address width of the memory (depth 2**ADDR_W bytes; 10 gives 1024 bytes).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- p0_req  in  1  port 0 request; held with payload until p0_ack
- p0_we  in  1  port 0: 1 = word write, 0 = word read
- p0_addr  in  32  port 0 byte address
- p0_wdata  in  32  port 0 write data
- p0_ack  out  1  port 0 one-cycle completion pulse
- p0_err  out  1  port 0 error flag, valid with p0_ack
- p0_rdata  out  32  port 0 read data, valid with p0_ack
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_err, p1_rdata: same as port 0, for port 1
- mem_addr  out  32  memory address (Addr)
- mem_wdata  out  32  memory write data (DataW)
- mem_we  out  1  memory write enable (MemRW)
- mem_rdata  in  32  memory read data (DataR); registered by the memory one edge after address
- busy  out  1  high when state is not IDLE
- gnt_id  out  1  port owning the current or last transaction

Behaviour:
- Reset: state IDLE; mem_addr=0, mem_wdata=0, mem_we=0; all acks, errs and rdata = 0; busy=0; gnt_id=0; fairness pointer = port 0.
- State IDLE:
  - If neither req is high, stay in IDLE.
  - Otherwise arbitrate and, at the edge, latch the winner's we/addr/wdata and set gnt_id.
  - Error check on the latched request: addr[1:0]!=0 or addr[31:ADDR_W]!=0.
  - Error present: next state RESP with error flag set; no memory access.
  - No error: next state ISSUE.
- State ISSUE (one cycle):
  - mem_addr = latched addr; mem_wdata = latched wdata; mem_we = latched we.
  - Memory writes or captures read data at the closing edge.
  - Next state RESP.
- State RESP (one cycle):
  - Granted port: ack=1; err = error flag.
  - rdata = mem_rdata if read without error, else 0.
  - Non-granted port: ack=0, rdata=0.
  - mem_we=0 and mem_addr=0 in this cycle.
  - Next state IDLE.
- Outside RESP: every ack=0, err=0, rdata=0.
- mem_we is high only in ISSUE, never in IDLE or RESP.
- Latency and throughput:
  - Valid access: req high in IDLE cycle N, issue N+1, ack N+2.
  - Error: ack N+1.
  - Best throughput is one access per 3 cycles; gaps are required between transactions.
- Requester rules:
  - Must hold req and payload stable until ack.
  - Must drop req in the cycle after ack; req still high in IDLE is a new request.
  - Payload changes after grant are ignored (latched copy is used).
  - A req dropped mid-transaction does not abort; the transaction completes and ack still pulses.
- Arbitration (default, macro undefined): fixed priority, port 0 wins when both are high; port 1 can starve.
- Simultaneous events: requests arriving in ISSUE or RESP wait, then are arbitrated in the next IDLE.
- Reset mid-operation:
  - rst in ISSUE: the write is suppressed only if rst is sampled before that ISSUE edge, i.e. the state was reset earlier. rst asserted in the ISSUE cycle itself still lets the memory edge occur with mem_we=1.
  - Following cycle: IDLE, all outputs at reset values, no ack is produced.
- Boundaries with ADDR_W=10:
  - Highest legal address is 0x3FC.
  - 0x400 → err.
  - 0x3FE → err (misaligned).
  - 0xFFFFFFFC → err.

Optional Feature:
- Macro: DMEM_ARB_FAIR_EN.
- Defined: round-robin arbitration.
  - A 1-bit pointer names the preferred port.
  - When both requests are high, the pointer's port wins.
  - After any grant, including error grants, the pointer moves to the other port.
  - A single requester always wins regardless of the pointer.
- Undefined: fixed priority, port 0 first; no pointer register exists.

Test Plan:
- Write then read: p0 write 0x0000_0010 ← 0xDEADBEEF; ack at N+2, err=0. p0 read 0x10 → p0_rdata=0xDEADBEEF with ack. p1 read 0x10 → same value (little-endian byte layout preserved).
- Both ports request in the same cycle: p0 reads 0x20, p1 writes 0x20 ← 0x12345678.
  - Default: p0 is served first and reads the old value; p1 acks 3 cycles later.
  - With DMEM_ARB_FAIR_EN and pointer at port 1: p1 is served first; p0 then reads 0x12345678.
- Errors: p1 write to 0x0000_0002 → ack at N+1, err=1, mem_we never high; p0 read of 0x400 → err=1, rdata=0. A following read of 0x0 returns its previous contents unchanged.
- Boundary: write 0xCAFEF00D to 0x3FC, read it back → 0xCAFEF00D, err=0.
- Reset mid-operation: p0 write 0x30 ← 0x11111111, rst high in the IDLE→ISSUE grant cycle → mem_we stays 0, no ack, busy=0 next cycle. Read of 0x30 returns its pre-test value.
- Held req: p0 keeps req high for 6 cycles on a read of 0x40 → two transactions, acks 3 cycles apart. Payload changed after grant → the ack returns data for the latched address.
